// File: rtl/projector_pkg.sv
// Types and constants shared by the GPIO pattern-select front end and the
// pattern renderer.
package projector_pkg;

   typedef enum logic [1:0] {
      MODE_VERTICAL   = 2'd0,
      MODE_HORIZONTAL = 2'd1,
      MODE_SMILEY     = 2'd2
   } mode_t;

   localparam logic [2:0] CODE_VERTICAL   = 3'b000;
   localparam logic [2:0] CODE_HORIZONTAL = 3'b111;
   localparam logic [2:0] CODE_SMILEY     = 3'b010;

   typedef enum logic [1:0] {
      STABLE,
      SETTLING,
      PENDING
   } sel_state_t;

   function automatic logic code_valid(input logic [2:0] code);
      return (code == CODE_VERTICAL) || (code == CODE_HORIZONTAL) ||
             (code == CODE_SMILEY);
   endfunction

   // Invalid codes map to VERTICAL but are never committed.
   function automatic mode_t code_to_mode(input logic [2:0] code);
      case (code)
         CODE_HORIZONTAL: return MODE_HORIZONTAL;
         CODE_SMILEY:     return MODE_SMILEY;
         default:         return MODE_VERTICAL;
      endcase
   endfunction

endpackage

// File: rtl/gpio_sync.sv
// Per-bit multi-flop synchroniser for asynchronous GPIO pins.
module gpio_sync #(
   parameter int WIDTH  = 3,
   parameter int STAGES = 2
) (
   input  logic             clk25MHz,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [STAGES-1:0] chain;

      always_ff @(posedge clk25MHz or posedge reset) begin
         if (reset) chain <= '0;
         else       chain <= {chain[STAGES-2:0], d[i]};
      end

      assign q[i] = chain[STAGES-1];
   end

endmodule

// File: rtl/gpio_pattern_select.sv
// Synchronises and debounces the pattern-select pins, then commits the
// decoded pattern mode only on a frame boundary.
module gpio_pattern_select
   import projector_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic       clk25MHz,
   input  logic       reset,
   input  logic [2:0] gpio_in,
   input  logic       frame_start,
   output logic [1:0] mode,
   output logic       mode_valid,
   output logic       mode_update,
   output logic [2:0] stable_code
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [2:0]       sync_code;
   logic [2:0]       candidate;
   logic [CNT_W-1:0] cnt;
   mode_t            mode_q;
   sel_state_t       state;

   gpio_sync #(
      .WIDTH  (3),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk25MHz (clk25MHz),
      .reset    (reset),
      .d        (gpio_in),
      .q        (sync_code)
   );

   // Reset lands in SETTLING with candidate 000, so an idle 000 input is
   // still debounced and committed like any other code.
   always_ff @(posedge clk25MHz or posedge reset) begin
      if (reset) begin
         state       <= SETTLING;
         candidate   <= 3'b000;
         cnt         <= '0;
         stable_code <= 3'b000;
         mode_q      <= MODE_VERTICAL;
         mode_valid  <= 1'b0;
         mode_update <= 1'b0;
      end else begin
         mode_update <= 1'b0;
         case (state)
            STABLE: begin
               if (sync_code != stable_code) begin
                  candidate <= sync_code;
                  cnt       <= '0;
                  state     <= SETTLING;
               end
            end
            SETTLING: begin
               if (sync_code != candidate) begin
                  candidate <= sync_code;
                  cnt       <= '0;
               end else if (cnt == CNT_LAST) begin
                  stable_code <= candidate;
                  if (code_valid(candidate) &&
                      ((code_to_mode(candidate) != mode_q) || !mode_valid))
                     state <= PENDING;
                  else
                     state <= STABLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PENDING: begin
               // An input change outranks a coincident frame_start.
               if (sync_code != stable_code) begin
                  candidate <= sync_code;
                  cnt       <= '0;
                  state     <= SETTLING;
               end else if (frame_start) begin
                  mode_q      <= code_to_mode(stable_code);
                  mode_valid  <= 1'b1;
                  mode_update <= 1'b1;
                  state       <= STABLE;
               end
            end
            default: state <= SETTLING;
         endcase
      end
   end

   assign mode = mode_q;

endmodule
